// File: rtl/suerv_pkg.sv
// Shared types and constants for the SueRV32 fetch front end.
package suerv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam int unsigned ILEN_BYTES    = 4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Next-PC priority select: trap, then redirect (misaligned targets divert to the
// trap vector), then sequential pc + 4 with natural 32-bit wrap.
module fetch_npc_sel
  import suerv_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        trap_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] npc_o,
  output logic        misalign_o
);

  always_comb begin
    misalign_o = 1'b0;
    npc_o      = pc_i + 32'(ILEN_BYTES);
    if (trap_i) begin
      npc_o = TRAP_VEC;
    end else if (redirect_i) begin
      if (is_misaligned(target_i)) begin
        npc_o      = TRAP_VEC;
        misalign_o = 1'b1;
      end else begin
        npc_o = target_i;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// SueRV32 fetch sequencer: owns the PC, runs a single-outstanding req/gnt/rvalid
// handshake to instruction memory and presents fetched words to decode.
module fetch_ctrl
  import suerv_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        misalign_o,
  output logic [31:0] pc_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q;
  logic         req_q;
  logic         kill_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         misalign_q;

  logic [31:0]  npc;
  logic         npc_misalign;
  logic         flush;
  logic         retire;

  fetch_npc_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_npc_sel (
    .trap_i     (trap_i),
    .redirect_i (redirect_i),
    .target_i   (redirect_pc_i),
    .pc_i       (pc_q),
    .npc_o      (npc),
    .misalign_o (npc_misalign)
  );

  assign flush  = trap_i | redirect_i;
  // A redirect arriving with the data flushes it just like an earlier kill would.
  assign retire = (state_q == WAIT) && imem_rvalid_i && !kill_q && !flush;

  // With no kill pending, pc_q equals the address on the bus while in REQ,
  // so the sequential mux output is exactly the granted address + 4.
  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = npc;
    end else if (state_q == REQ && imem_gnt_i && !kill_q) begin
      pc_d = npc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VEC;
      addr_q        <= RESET_VEC;
      req_q         <= 1'b0;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0000_0000;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      misalign_q    <= npc_misalign;
      instr_valid_q <= retire | (instr_valid_q & stall_i & ~flush);
      if (retire) begin
        instr_q    <= imem_rdata_i;
        instr_pc_q <= addr_q;
      end
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_d;
        end
        REQ: begin
          kill_q <= kill_q | flush;
          if (imem_gnt_i) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            kill_q <= 1'b0;
            if (retire && stall_i) begin
              state_q <= HOLD;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_d;
            end
          end else begin
            kill_q <= kill_q | flush;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_d;
          end
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign misalign_o    = misalign_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, stall hold, redirect kill,
// misalign, trap priority with withheld grant, PC wrap and mid-flight reset.
module tb_fetch_ctrl;
  import suerv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        trap_i = 1'b0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        misalign_o;
  logic [31:0] pc_o;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .misalign_o    (misalign_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: all are entered and left at a negative edge.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_gnt();
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [31:0] data);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
  endtask

  task automatic pulse_redirect(input logic trap, input logic redir, input logic [31:0] target);
    trap_i        = trap;
    redirect_i    = redir;
    redirect_pc_i = target;
    @(negedge clk);
    trap_i     = 1'b0;
    redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", pc_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instr_o); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp 00000000", instr_pc_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h exp 0", misalign_o); end
    rstn = 1'b1;
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] exp_addr;
    logic [31:0] data;
    for (int k = 0; k < 3; k++) begin
      exp_addr = 32'(4 * k);
      data     = 32'h1000_0000 + 32'(k);
      wait_req(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL seq_req_timeout got %h exp 1", ok); end
      checks++; if (imem_addr_o !== exp_addr) begin errors++; $display("FAIL seq_addr got %h exp %h", imem_addr_o, exp_addr); end
      pulse_gnt();
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL seq_valid_drop got %h exp 0", instr_valid_o); end
      pulse_rvalid(data);
      checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid got %h exp 1", instr_valid_o); end
      checks++; if (instr_o !== data) begin errors++; $display("FAIL seq_instr got %h exp %h", instr_o, data); end
      checks++; if (instr_pc_o !== exp_addr) begin errors++; $display("FAIL seq_instr_pc got %h exp %h", instr_pc_o, exp_addr); end
      $display("txn seq pc=%h instr=%h", instr_pc_o, instr_o);
    end
  endtask

  task automatic test_stall();
    bit ok;
    wait_req(ok);
    checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("FAIL stall_addr got %h exp 0000000c", imem_addr_o); end
    stall_i = 1'b1;
    pulse_gnt();
    pulse_rvalid(32'h00A0_0093);
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got %h exp 1", instr_valid_o); end
      checks++; if (instr_o !== 32'h00A0_0093) begin errors++; $display("FAIL stall_instr got %h exp 00a00093", instr_o); end
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_no_req got %h exp 0", imem_req_o); end
      @(negedge clk);
    end
    stall_i = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_release_req got %h exp 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL stall_release_addr got %h exp 00000010", imem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %h exp 0", instr_valid_o); end
    $display("txn stall pc=%h instr=%h", instr_pc_o, instr_o);
  endtask

  task automatic test_redirect_wait();
    pulse_gnt();
    pulse_redirect(1'b0, 1'b1, 32'h0000_0040);
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp 00000040", pc_o); end
    pulse_rvalid(32'hDEAD_BEEF);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_killed_valid got %h exp 0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL redir_req got %h exp 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp 00000040", imem_addr_o); end
    pulse_gnt();
    pulse_rvalid(32'h0000_0513);
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL redir_fetch_valid got %h exp 1", instr_valid_o); end
    checks++; if (instr_pc_o !== 32'h40) begin errors++; $display("FAIL redir_fetch_pc got %h exp 00000040", instr_pc_o); end
    $display("txn redirect pc=%h instr=%h", instr_pc_o, instr_o);
  endtask

  task automatic test_misalign();
    pulse_gnt();
    pulse_redirect(1'b0, 1'b1, 32'h0000_0042);
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_pulse got %h exp 1", misalign_o); end
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL mis_pc got %h exp 00000100", pc_o); end
    @(negedge clk);
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %h exp 0", misalign_o); end
    pulse_rvalid(32'hBAD0_0001);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL mis_killed_valid got %h exp 0", instr_valid_o); end
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL mis_addr got %h exp 00000100", imem_addr_o); end
    pulse_gnt();
    pulse_rvalid(32'h3420_2573);
    checks++; if (instr_pc_o !== 32'h100) begin errors++; $display("FAIL mis_fetch_pc got %h exp 00000100", instr_pc_o); end
    $display("txn misalign pc=%h instr=%h", instr_pc_o, instr_o);
  endtask

  task automatic test_trap_priority();
    checks++; if (imem_addr_o !== 32'h104) begin errors++; $display("FAIL trap_pre_addr got %h exp 00000104", imem_addr_o); end
    pulse_redirect(1'b1, 1'b1, 32'h0000_0080);
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL trap_misalign got %h exp 0", misalign_o); end
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL trap_pc got %h exp 00000100", pc_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL trap_hold_req got %h exp 1", imem_req_o); end
      checks++; if (imem_addr_o !== 32'h104) begin errors++; $display("FAIL trap_hold_addr got %h exp 00000104", imem_addr_o); end
      @(negedge clk);
    end
    pulse_gnt();
    pulse_rvalid(32'hBAD0_0002);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL trap_killed_valid got %h exp 0", instr_valid_o); end
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL trap_addr got %h exp 00000100", imem_addr_o); end
    $display("txn trap next_addr=%h", imem_addr_o);
  endtask

  task automatic test_wrap();
    pulse_redirect(1'b0, 1'b1, 32'hFFFF_FFFC);
    pulse_gnt();
    pulse_rvalid(32'hBAD0_0003);
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_addr got %h exp fffffffc", imem_addr_o); end
    pulse_gnt();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", pc_o); end
    pulse_rvalid(32'h0010_0073);
    checks++; if (instr_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc got %h exp fffffffc", instr_pc_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr_o); end
    $display("txn wrap pc=%h instr=%h", instr_pc_o, instr_o);
  endtask

  task automatic test_reset_midflight();
    pulse_gnt();
    rstn = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mrst_req got %h exp 0", imem_req_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL mrst_pc got %h exp 00000000", pc_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid got %h exp 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL mrst_instr got %h exp 00000013", instr_o); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL mrst_instr_pc got %h exp 00000000", instr_pc_o); end
    @(negedge clk);
    rstn          = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_0004;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_late_rvalid got %h exp 0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL mrst_refetch_req got %h exp 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL mrst_refetch_addr got %h exp 00000000", imem_addr_o); end
    pulse_gnt();
    pulse_rvalid(32'h0000_0297);
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL mrst_fetch_pc got %h exp 00000000", instr_pc_o); end
    checks++; if (instr_o !== 32'h0000_0297) begin errors++; $display("FAIL mrst_fetch_instr got %h exp 00000297", instr_o); end
    $display("txn refetch pc=%h instr=%h", instr_pc_o, instr_o);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_misalign();
    test_trap_priority();
    test_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
